// File: rtl/timing_pkg.sv
// Shared constants, sequencer state encoding and width helper for the timing generator.
package timing_pkg;

   localparam int unsigned PH_W = 0;
   localparam int unsigned PH_X = 1;
   localparam int unsigned PH_Y = 2;
   localparam int unsigned PH_Z = 3;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRunning = 2'd1,
      StHold    = 2'd2
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/timing_fanout.sv
// Registers one phase bit into FANOUT identical copies.
module timing_fanout #(
   parameter int unsigned FANOUT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              phase_i,
   output logic [FANOUT-1:0] copies_o
);

   logic [FANOUT-1:0] copies_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         copies_q <= '0;
      end else begin
         copies_q <= {FANOUT{phase_i}};
      end
   end

   assign copies_o = copies_q;

endmodule

// File: rtl/timing_gen.sv
// Multiphase non-overlapping clock generator: sequencer, prescaler, bit-time counter
// and per-phase registered fan-out, with free-run and single-step modes.
module timing_gen
   import timing_pkg::*;
#(
   parameter int unsigned NUM_PHASES    = 4,
   parameter int unsigned FANOUT        = 8,
   parameter int unsigned DIV           = 2,
   parameter int unsigned BITS_PER_WORD = 26
) (
   input  logic                             SIM_CLK,
   input  logic                             SIM_RST,
   input  logic                             RUN,
   input  logic                             MODE,
   input  logic                             STEP,
   output logic [NUM_PHASES*FANOUT-1:0]     PHASE_OUT,
   output logic [clog2(NUM_PHASES)-1:0]     PHASE_IDX,
   output logic [clog2(BITS_PER_WORD)-1:0]  BIT_TIME,
   output logic                             WORD_STB,
   output logic                             BUSY
);

   localparam int unsigned IW = clog2(NUM_PHASES);
   localparam int unsigned BW = clog2(BITS_PER_WORD);
   localparam int unsigned PW = (clog2(DIV) > 0) ? clog2(DIV) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PHASES - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   state_e                state_q, state_d;
   logic [PW-1:0]         pre_q, pre_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  started_q, started_d;
   logic                  wrap_q, wrap_d;
   logic                  stb_q;
   logic                  step_q;
   logic [NUM_PHASES-1:0] onehot_q, onehot_d;
   logic                  step_edge;
   logic                  pre_tc;
   logic                  advance;

   assign step_edge = STEP & ~step_q;
   assign pre_tc    = (pre_q == PRE_LAST);

   always_comb begin
      state_d   = state_q;
      advance   = 1'b0;
      idx_d     = idx_q;
      bit_d     = bit_q;
      started_d = started_q;
      wrap_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (RUN && !MODE) begin
               state_d = StRunning;
               advance = 1'b1;
            end else if (RUN && MODE && step_edge) begin
               state_d = StHold;
               advance = 1'b1;
            end
         end
         StRunning: begin
            // Leave only at a phase boundary so the last phase keeps its full width.
            if (pre_tc) begin
               if (!RUN || MODE) begin
                  state_d = StIdle;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         StHold: begin
            if (pre_tc) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      pre_d = (state_q == StIdle || pre_tc) ? '0 : pre_q + 1'b1;

      // The very first advance out of reset lands on W without counting a bit time.
      if (advance) begin
         started_d = 1'b1;
         if (idx_q == IDX_LAST) begin
            idx_d = IW'(PH_W);
            if (started_q) begin
               if (bit_q == BIT_LAST) begin
                  bit_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      for (int p = 0; p < NUM_PHASES; p++) begin
         onehot_d[p] = (state_q != StIdle) && (idx_q == IW'(p));
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q   <= StIdle;
         pre_q     <= '0;
         idx_q     <= IDX_LAST;
         bit_q     <= '0;
         started_q <= 1'b0;
         wrap_q    <= 1'b0;
         stb_q     <= 1'b0;
         step_q    <= 1'b0;
         onehot_q  <= '0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         idx_q     <= idx_d;
         bit_q     <= bit_d;
         started_q <= started_d;
         wrap_q    <= wrap_d;
         stb_q     <= wrap_q;
         step_q    <= STEP;
         onehot_q  <= onehot_d;
      end
   end

   for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
      timing_fanout #(
         .FANOUT(FANOUT)
      ) u_fanout (
         .clk_i   (SIM_CLK),
         .rst_ni  (SIM_RST),
         .phase_i (onehot_q[p]),
         .copies_o(PHASE_OUT[p*FANOUT +: FANOUT])
      );
   end

   assign PHASE_IDX = idx_q;
   assign BIT_TIME  = bit_q;
   assign WORD_STB  = stb_q;
   assign BUSY      = |PHASE_OUT;

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: default build plus a 6-phase, DIV=1 build.
module tb_timing_gen;

   logic        SIM_CLK;
   logic        SIM_RST;
   logic        RUN;
   logic        MODE;
   logic        STEP;
   logic        run2;

   logic [31:0] phase_out;
   logic [1:0]  phase_idx;
   logic [4:0]  bit_time;
   logic        word_stb;
   logic        busy;

   logic [17:0] phase_out2;
   logic [2:0]  phase_idx2;
   logic [1:0]  bit_time2;
   logic        word_stb2;
   logic        busy2;

   int checks;
   int errors;

   timing_gen dut (
      .SIM_CLK  (SIM_CLK),
      .SIM_RST  (SIM_RST),
      .RUN      (RUN),
      .MODE     (MODE),
      .STEP     (STEP),
      .PHASE_OUT(phase_out),
      .PHASE_IDX(phase_idx),
      .BIT_TIME (bit_time),
      .WORD_STB (word_stb),
      .BUSY     (busy)
   );

   timing_gen #(
      .NUM_PHASES   (6),
      .FANOUT       (3),
      .DIV          (1),
      .BITS_PER_WORD(4)
   ) dut2 (
      .SIM_CLK  (SIM_CLK),
      .SIM_RST  (SIM_RST),
      .RUN      (run2),
      .MODE     (1'b0),
      .STEP     (1'b0),
      .PHASE_OUT(phase_out2),
      .PHASE_IDX(phase_idx2),
      .BIT_TIME (bit_time2),
      .WORD_STB (word_stb2),
      .BUSY     (busy2)
   );

   initial SIM_CLK = 1'b0;
   always #5 SIM_CLK = ~SIM_CLK;

   typedef struct packed {
      logic       rst_n;
      logic       run;
      logic       mode;
      logic       step;
      logic [3:0] ph;
      logic [1:0] idx;
      logic [4:0] bt;
      logic       stb;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge SIM_CLK);
      #1;
   endtask

   function automatic logic [31:0] expand4(input logic [3:0] ph);
      logic [31:0] r;
      for (int p = 0; p < 4; p++) begin
         for (int f = 0; f < 8; f++) begin
            r[p*8+f] = ph[p];
         end
      end
      return r;
   endfunction

   function automatic logic [17:0] expand6(input logic [5:0] ph);
      logic [17:0] r;
      for (int p = 0; p < 6; p++) begin
         for (int f = 0; f < 3; f++) begin
            r[p*3+f] = ph[p];
         end
      end
      return r;
   endfunction

   // Free-run expectations k edges after RUN is first sampled (default build).
   function automatic logic [3:0] ph4(input int k);
      logic [3:0] r;
      r = '0;
      if (k >= 2) r[((k-2)/2)%4] = 1'b1;
      return r;
   endfunction

   function automatic logic [8:0] stat4(input int k);
      return {2'((k/2)%4), 5'((k/8)%26), (k > 1 && k%208 == 1), (k >= 2)};
   endfunction

   function automatic logic [5:0] ph6(input int k);
      logic [5:0] r;
      r = '0;
      if (k >= 2) r[(k-2)%6] = 1'b1;
      return r;
   endfunction

   function automatic logic [6:0] stat6(input int k);
      return {3'(k%6), 2'((k/6)%4), (k > 1 && k%24 == 1), (k >= 2)};
   endfunction

   initial begin
      int stb_cnt;
      logic [3:0] eph;
      logic [1:0] eidx;

      checks  = 0;
      errors  = 0;
      SIM_RST = 1'b0;
      RUN     = 1'b0;
      MODE    = 1'b0;
      STEP    = 1'b0;
      run2    = 1'b0;

      // Reset, start, W/X/Y/Z, drop RUN mid-phase, resume at the next phase.
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 5'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 5'd0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 5'd0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 5'd0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 2'd1, 5'd0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 2'd1, 5'd0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 2'd2, 5'd0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 2'd2, 5'd0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 2'd3, 5'd0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 2'd3, 5'd0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 2'd0, 5'd1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 2'd0, 5'd1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 2'd1, 5'd1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 2'd1, 5'd1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 2'd1, 5'd1, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 2'd1, 5'd1, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd1, 5'd1, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd2, 5'd1, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 2'd2, 5'd1, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 2'd3, 5'd1, 1'b0};
      vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 2'd3, 5'd1, 1'b0};
      vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 2'd0, 5'd2, 1'b0};

      for (int v = 0; v < NV; v++) begin
         SIM_RST = vecs[v].rst_n;
         RUN     = vecs[v].run;
         MODE    = vecs[v].mode;
         STEP    = vecs[v].step;
         tick();
         check($sformatf("vec%0d_out", v), 64'(phase_out), 64'(expand4(vecs[v].ph)));
         check($sformatf("vec%0d_stat", v), 64'({phase_idx, bit_time, word_stb, busy}),
               64'({vecs[v].idx, vecs[v].bt, vecs[v].stb, |vecs[v].ph}));
      end
      check("dut2_idle_stat", 64'({phase_out2, phase_idx2, bit_time2, word_stb2, busy2}),
            64'({18'h0, 3'd5, 2'd0, 1'b0, 1'b0}));

      // Free-run across two word wraps, then reset asynchronously in the middle of Y.
      RUN     = 1'b0;
      SIM_RST = 1'b0;
      tick();
      SIM_RST = 1'b1;
      RUN     = 1'b1;
      stb_cnt = 0;
      for (int k = 0; k <= 422; k++) begin
         tick();
         check("free_out", 64'(phase_out), 64'(expand4(ph4(k))));
         check("free_stat", 64'({phase_idx, bit_time, word_stb, busy}), 64'(stat4(k)));
         if (word_stb) stb_cnt++;
      end
      check("free_stb_count", 64'(stb_cnt), 64'd2);
      check("pre_reset_is_y", 64'(phase_out), 64'(expand4(4'h4)));
      #2;
      SIM_RST = 1'b0;
      #1;
      check("async_rst", 64'({phase_out, phase_idx, bit_time, word_stb, busy}),
            64'({32'h0, 2'd3, 5'd0, 1'b0, 1'b0}));
      tick();
      SIM_RST = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         tick();
         check("restart_out", 64'(phase_out), 64'(expand4(ph4(k))));
         check("restart_stat", 64'({phase_idx, bit_time, word_stb, busy}), 64'(stat4(k)));
      end

      // Single-step: W, X, Y, the last with STEP held high for four cycles.
      RUN     = 1'b0;
      SIM_RST = 1'b0;
      tick();
      SIM_RST = 1'b1;
      MODE    = 1'b1;
      RUN     = 1'b1;
      for (int c = 0; c < 40; c++) begin
         STEP = (c == 0) || (c == 10) || (c >= 20 && c <= 23);
         tick();
         eph  = (c == 2 || c == 3)   ? 4'h1 :
                (c == 12 || c == 13) ? 4'h2 :
                (c == 22 || c == 23) ? 4'h4 : 4'h0;
         eidx = (c < 10) ? 2'd0 : (c < 20) ? 2'd1 : 2'd2;
         check($sformatf("step_out_c%0d", c), 64'(phase_out), 64'(expand4(eph)));
         check($sformatf("step_stat_c%0d", c), 64'({phase_idx, busy}), 64'({eidx, |eph}));
      end
      STEP = 1'b0;

      // STEP edge with RUN low in single-step mode must do nothing.
      RUN = 1'b0;
      for (int c = 0; c < 8; c++) begin
         STEP = (c == 2);
         tick();
         check("step_run_low", 64'({phase_out, phase_idx, busy}), 64'({32'h0, 2'd2, 1'b0}));
      end
      STEP = 1'b0;
      MODE = 1'b0;

      // Six-phase DIV=1 build: one-cycle phases, word strobe every 24 cycles.
      SIM_RST = 1'b0;
      tick();
      SIM_RST = 1'b1;
      run2    = 1'b1;
      stb_cnt = 0;
      for (int k = 0; k <= 60; k++) begin
         tick();
         check("p6_out", 64'(phase_out2), 64'(expand6(ph6(k))));
         check("p6_stat", 64'({phase_idx2, bit_time2, word_stb2, busy2}), 64'(stat6(k)));
         if (word_stb2) stb_cnt++;
      end
      check("p6_stb_count", 64'(stb_cnt), 64'd2);
      run2 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
